// File: rtl/pzcorebus_outstanding_limiter_if.sv
// Minimal pzcorebus package and command/data/response interface used by the outstanding limiter.
// A zero field in the bus configuration selects the default width for that field.
package pzcorebus_pkg;
    typedef struct packed {
        logic [15:0] id_width;
        logic [15:0] address_width;
        logic [15:0] data_width;
        logic [15:0] length_width;
    } pzcorebus_config;

    typedef enum logic [2:0] {
        PZCOREBUS_NULL               = 3'b000,
        PZCOREBUS_READ               = 3'b001,
        PZCOREBUS_WRITE              = 3'b010,
        PZCOREBUS_WRITE_NON_POSTED   = 3'b011,
        PZCOREBUS_BROADCAST          = 3'b100,
        PZCOREBUS_ATOMIC             = 3'b101,
        PZCOREBUS_MESSAGE            = 3'b110,
        PZCOREBUS_MESSAGE_NON_POSTED = 3'b111
    } pzcorebus_command_type;

    typedef enum logic {
        PZCOREBUS_RESPONSE           = 1'b0,
        PZCOREBUS_RESPONSE_WITH_DATA = 1'b1
    } pzcorebus_response_type;

    function automatic int get_id_width(pzcorebus_config cfg);
        return (cfg.id_width != 16'd0) ? int'(cfg.id_width) : 4;
    endfunction

    function automatic int get_address_width(pzcorebus_config cfg);
        return (cfg.address_width != 16'd0) ? int'(cfg.address_width) : 32;
    endfunction

    function automatic int get_data_width(pzcorebus_config cfg);
        return (cfg.data_width != 16'd0) ? int'(cfg.data_width) : 32;
    endfunction

    function automatic int get_length_width(pzcorebus_config cfg);
        return (cfg.length_width != 16'd0) ? int'(cfg.length_width) : 8;
    endfunction
endpackage

interface pzcorebus_if #(
    parameter pzcorebus_pkg::pzcorebus_config BUS_CONFIG = '0
);
    localparam int ID_WIDTH      = pzcorebus_pkg::get_id_width(BUS_CONFIG);
    localparam int ADDRESS_WIDTH = pzcorebus_pkg::get_address_width(BUS_CONFIG);
    localparam int DATA_WIDTH    = pzcorebus_pkg::get_data_width(BUS_CONFIG);
    localparam int LENGTH_WIDTH  = pzcorebus_pkg::get_length_width(BUS_CONFIG);

    logic                                   mcmd_valid;
    logic                                   scmd_accept;
    pzcorebus_pkg::pzcorebus_command_type   mcmd;
    logic [ID_WIDTH-1:0]                    mid;
    logic [ADDRESS_WIDTH-1:0]               maddr;
    logic [LENGTH_WIDTH-1:0]                mlength;
    logic                                   mdata_valid;
    logic                                   sdata_accept;
    logic [DATA_WIDTH-1:0]                  mdata;
    logic                                   mdata_last;
    logic                                   sresp_valid;
    logic                                   mresp_accept;
    pzcorebus_pkg::pzcorebus_response_type  sresp;
    logic [ID_WIDTH-1:0]                    sid;
    logic                                   serror;
    logic [DATA_WIDTH-1:0]                  sdata;
    logic [1:0]                             sresp_last;

    modport master (
        output mcmd_valid, mcmd, mid, maddr, mlength,
        output mdata_valid, mdata, mdata_last,
        output mresp_accept,
        input  scmd_accept, sdata_accept,
        input  sresp_valid, sresp, sid, serror, sdata, sresp_last
    );

    modport slave (
        input  mcmd_valid, mcmd, mid, maddr, mlength,
        input  mdata_valid, mdata, mdata_last,
        input  mresp_accept,
        output scmd_accept, sdata_accept,
        output sresp_valid, sresp, sid, serror, sdata, sresp_last
    );
endinterface

// File: rtl/pzcorebus_outstanding_limiter.sv
// Throttles non-posted commands to MAX_OUTSTANDING in flight and offers a drain/idle handshake.
// Optional stall counter: PZCOREBUS_OUTSTANDING_LIMITER_STALL_COUNTER_EN.
module pzcorebus_outstanding_limiter
    import pzcorebus_pkg::*;
#(
    parameter pzcorebus_config BUS_CONFIG          = '0,
    parameter int              MAX_OUTSTANDING     = 8,
    parameter int              COUNT_WIDTH         = $clog2(MAX_OUTSTANDING + 1),
    parameter int              STALL_COUNTER_WIDTH = 32
)(
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_clear,
    input  logic                           i_drain,
    output logic                           o_idle,
    output logic [COUNT_WIDTH-1:0]         o_outstanding_count,
    output logic                           o_limit_reached,
    output logic [STALL_COUNTER_WIDTH-1:0] o_stall_count,
    pzcorebus_if.slave                     slave_if,
    pzcorebus_if.master                    master_if
);
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        IDLE  = 2'd2
    } state_e;

    state_e                 state;
    state_e                 state_next;
    logic [COUNT_WIDTH-1:0] count;
    logic                   non_posted;
    logic                   limit_reached;
    logic                   block;
    logic                   count_up;
    logic                   count_down;

    // Only registered state feeds block, so a freed slot is usable one cycle later.
    assign non_posted    = !(slave_if.mcmd inside {PZCOREBUS_WRITE, PZCOREBUS_BROADCAST, PZCOREBUS_MESSAGE});
    assign limit_reached = (count == COUNT_WIDTH'(MAX_OUTSTANDING));
    assign block         = (state != RUN) || (limit_reached && non_posted);

    assign master_if.mcmd_valid = slave_if.mcmd_valid && !block;
    assign slave_if.scmd_accept = master_if.scmd_accept && !block;
    assign master_if.mcmd       = slave_if.mcmd;
    assign master_if.mid        = slave_if.mid;
    assign master_if.maddr      = slave_if.maddr;
    assign master_if.mlength    = slave_if.mlength;

    assign master_if.mdata_valid  = slave_if.mdata_valid;
    assign master_if.mdata        = slave_if.mdata;
    assign master_if.mdata_last   = slave_if.mdata_last;
    assign slave_if.sdata_accept  = master_if.sdata_accept;

    assign slave_if.sresp_valid   = master_if.sresp_valid;
    assign slave_if.sresp         = master_if.sresp;
    assign slave_if.sid           = master_if.sid;
    assign slave_if.serror        = master_if.serror;
    assign slave_if.sdata         = master_if.sdata;
    assign slave_if.sresp_last    = master_if.sresp_last;
    assign master_if.mresp_accept = slave_if.mresp_accept;

    assign count_up   = slave_if.mcmd_valid && slave_if.scmd_accept && non_posted;
    assign count_down = master_if.sresp_valid && slave_if.mresp_accept && master_if.sresp_last[0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count <= '0;
        end else if (i_clear) begin
            count <= '0;
        end else if (count_up && !count_down) begin
            count <= count + COUNT_WIDTH'(1);
        end else if (count_down && !count_up && (count != '0)) begin
            count <= count - COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= RUN;
        end else if (i_clear) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (i_drain) state_next = DRAIN;
            DRAIN:   if (!i_drain) state_next = RUN;
                     else if (count == '0) state_next = IDLE;
            IDLE:    if (!i_drain) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    assign o_idle              = (state == IDLE);
    assign o_outstanding_count = count;
    assign o_limit_reached     = limit_reached;

`ifdef PZCOREBUS_OUTSTANDING_LIMITER_STALL_COUNTER_EN
    logic [STALL_COUNTER_WIDTH-1:0] stall_count;
    logic                           stall;

    assign stall = slave_if.mcmd_valid && (state == RUN) && limit_reached && non_posted;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_count <= '0;
        end else if (i_clear) begin
            stall_count <= '0;
        end else if (stall && !(&stall_count)) begin
            stall_count <= stall_count + STALL_COUNTER_WIDTH'(1);
        end
    end

    assign o_stall_count = stall_count;
`else
    assign o_stall_count = '0;
`endif

    // Underflow is tolerated in hardware (count holds at 0) but flagged in simulation.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && !i_clear) begin
            assert (!(count_down && !count_up && (count == '0)));
        end
        if (i_rst_n) begin
            assert (count <= COUNT_WIDTH'(MAX_OUTSTANDING));
        end
        assert (int'($bits(master_if.mdata)) == get_data_width(BUS_CONFIG));
    end
endmodule

// File: tb/tb_pzcorebus_outstanding_limiter.sv
// Directed bench: limit throttling, response freeing, posted pass-through, multi-beat responses,
// drain/idle handshake (second instance, MAX_OUTSTANDING=4) and the optional stall counter.
`timescale 1ns/1ps
module tb_pzcorebus_outstanding_limiter;
    import pzcorebus_pkg::*;

    localparam int MAX_A = 2;
    localparam int MAX_B = 4;
    localparam int CW_A  = $clog2(MAX_A + 1);
    localparam int CW_B  = $clog2(MAX_B + 1);
`ifdef PZCOREBUS_OUTSTANDING_LIMITER_STALL_COUNTER_EN
    localparam logic [31:0] EXP_STALL = 32'd10;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
`endif

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic            clear = 1'b0;
    logic            drain = 1'b0;
    logic            idle_a, limit_a, idle_b, limit_b;
    logic [CW_A-1:0] count_a;
    logic [CW_B-1:0] count_b;
    logic [31:0]     stall_a, stall_b;
    int              errors = 0;
    int              checks = 0;

    pzcorebus_if up_a();
    pzcorebus_if dn_a();
    pzcorebus_if up_b();
    pzcorebus_if dn_b();

    pzcorebus_outstanding_limiter #(.MAX_OUTSTANDING(MAX_A)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_drain(drain),
        .o_idle(idle_a), .o_outstanding_count(count_a), .o_limit_reached(limit_a),
        .o_stall_count(stall_a), .slave_if(up_a), .master_if(dn_a)
    );

    pzcorebus_outstanding_limiter #(.MAX_OUTSTANDING(MAX_B)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_drain(drain),
        .o_idle(idle_b), .o_outstanding_count(count_b), .o_limit_reached(limit_b),
        .o_stall_count(stall_b), .slave_if(up_b), .master_if(dn_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input pzcorebus_command_type cmd);
        up_a.mcmd_valid = valid;
        up_a.mcmd       = cmd;
        up_a.maddr      = 32'h0000_1000;
        up_a.mlength    = 8'd0;
    endtask

    initial begin
        // Quiet defaults on every tb-driven signal of both instances.
        up_a.mcmd_valid = 1'b0; up_a.mcmd = PZCOREBUS_NULL; up_a.mid = '0; up_a.maddr = '0;
        up_a.mlength = '0; up_a.mdata_valid = 1'b0; up_a.mdata = '0; up_a.mdata_last = 1'b0;
        up_a.mresp_accept = 1'b0;
        dn_a.scmd_accept = 1'b0; dn_a.sdata_accept = 1'b0; dn_a.sresp_valid = 1'b0;
        dn_a.sresp = PZCOREBUS_RESPONSE_WITH_DATA; dn_a.sid = '0; dn_a.serror = 1'b0;
        dn_a.sdata = '0; dn_a.sresp_last = 2'b00;
        up_b.mcmd_valid = 1'b0; up_b.mcmd = PZCOREBUS_NULL; up_b.mid = '0; up_b.maddr = '0;
        up_b.mlength = '0; up_b.mdata_valid = 1'b0; up_b.mdata = '0; up_b.mdata_last = 1'b0;
        up_b.mresp_accept = 1'b0;
        dn_b.scmd_accept = 1'b0; dn_b.sdata_accept = 1'b0; dn_b.sresp_valid = 1'b0;
        dn_b.sresp = PZCOREBUS_RESPONSE_WITH_DATA; dn_b.sid = '0; dn_b.serror = 1'b0;
        dn_b.sdata = '0; dn_b.sresp_last = 2'b00;

        // Reset values and combinational pass-through while reset is held.
        #2;
        applyStimulus(1'b1, PZCOREBUS_READ);
        dn_a.scmd_accept = 1'b1;
        up_a.mdata_valid = 1'b1;
        up_a.mdata       = 32'h1234_5678;
        #1;
        checkOutput("rst_count", 64'(count_a), 64'd0);
        checkOutput("rst_limit", 64'(limit_a), 64'd0);
        checkOutput("rst_idle", 64'(idle_a), 64'd0);
        checkOutput("rst_stall", 64'(stall_a), 64'd0);
        checkOutput("rst_mcmd_valid", 64'(dn_a.mcmd_valid), 64'd1);
        checkOutput("rst_mdata", 64'(dn_a.mdata), 64'h1234_5678);
        applyStimulus(1'b0, PZCOREBUS_NULL);
        up_a.mdata_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Three reads with no responses: two pass, third is held.
        applyStimulus(1'b1, PZCOREBUS_READ);
        #1;
        checkOutput("rd1_accept", 64'(up_a.scmd_accept), 64'd1);
        tick();
        checkOutput("rd1_count", 64'(count_a), 64'd1);
        checkOutput("rd2_accept", 64'(up_a.scmd_accept), 64'd1);
        tick();
        checkOutput("rd2_count", 64'(count_a), 64'd2);
        checkOutput("rd2_limit", 64'(limit_a), 64'd1);
        checkOutput("rd3_accept_held", 64'(up_a.scmd_accept), 64'd0);
        checkOutput("rd3_mcmd_valid_held", 64'(dn_a.mcmd_valid), 64'd0);
        tick();
        checkOutput("rd3_count_hold", 64'(count_a), 64'd2);

        // Final response in cycle N frees a slot for cycle N+1 only.
        dn_a.sresp_valid  = 1'b1;
        dn_a.sresp_last   = 2'b01;
        up_a.mresp_accept = 1'b1;
        #1;
        checkOutput("resp_passthrough", 64'(up_a.sresp_valid), 64'd1);
        checkOutput("resp_same_cycle_blocked", 64'(up_a.scmd_accept), 64'd0);
        tick();
        dn_a.sresp_valid = 1'b0;
        #1;
        checkOutput("resp_n1_count", 64'(count_a), 64'd1);
        checkOutput("resp_n1_limit", 64'(limit_a), 64'd0);
        checkOutput("rd3_accept_n1", 64'(up_a.scmd_accept), 64'd1);
        tick();
        applyStimulus(1'b0, PZCOREBUS_NULL);
        checkOutput("rd3_count_back", 64'(count_a), 64'd2);

        // Posted write at the limit, then four data beats straight through.
        applyStimulus(1'b1, PZCOREBUS_WRITE);
        #1;
        checkOutput("wr_at_limit_accept", 64'(up_a.scmd_accept), 64'd1);
        checkOutput("wr_at_limit_valid", 64'(dn_a.mcmd_valid), 64'd1);
        tick();
        applyStimulus(1'b0, PZCOREBUS_NULL);
        checkOutput("wr_at_limit_count", 64'(count_a), 64'd2);
        dn_a.sdata_accept = 1'b1;
        up_a.mdata_valid  = 1'b1;
        for (int beat = 0; beat < 4; beat++) begin
            up_a.mdata      = 32'hD000_0000 + 32'(beat);
            up_a.mdata_last = (beat == 3);
            #1;
            checkOutput("data_beat_value", 64'(dn_a.mdata), 64'hD000_0000 + 64'(beat));
            checkOutput("data_beat_accept", 64'(up_a.sdata_accept), 64'd1);
            tick();
        end
        up_a.mdata_valid = 1'b0;
        up_a.mdata_last  = 1'b0;
        checkOutput("data_count_stays", 64'(count_a), 64'd2);

        // A stalled response is not a handshake; a four-beat response frees one slot after beat 4.
        dn_a.sresp_valid  = 1'b1;
        dn_a.sresp_last   = 2'b01;
        up_a.mresp_accept = 1'b0;
        tick();
        checkOutput("resp_backpressure", 64'(count_a), 64'd2);
        up_a.mresp_accept = 1'b1;
        for (int beat = 0; beat < 4; beat++) begin
            dn_a.sresp_last = (beat == 3) ? 2'b01 : 2'b00;
            tick();
            checkOutput("burst_resp_count", 64'(count_a), (beat == 3) ? 64'd1 : 64'd2);
        end
        dn_a.sresp_last = 2'b01;
        tick();
        dn_a.sresp_valid = 1'b0;
        checkOutput("single_resp_count", 64'(count_a), 64'd0);

        // Posted writes at count 0 all pass and never move the counter.
        applyStimulus(1'b1, PZCOREBUS_WRITE);
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("posted_accept", 64'(up_a.scmd_accept), 64'd1);
            tick();
        end
        applyStimulus(1'b0, PZCOREBUS_NULL);
        checkOutput("posted_count", 64'(count_a), 64'd0);

        // Read held by the limit for ten cycles, then clear.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checkOutput("clear_stall_start", 64'(stall_a), 64'd0);
        applyStimulus(1'b1, PZCOREBUS_READ);
        tick();
        tick();
        checkOutput("stall_count_at_limit", 64'(count_a), 64'd2);
        repeat (10) tick();
        checkOutput("stall_count_10", 64'(stall_a), 64'(EXP_STALL));
        checkOutput("stall_still_blocked", 64'(up_a.scmd_accept), 64'd0);
        applyStimulus(1'b0, PZCOREBUS_NULL);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checkOutput("clear_count", 64'(count_a), 64'd0);
        checkOutput("clear_limit", 64'(limit_a), 64'd0);
        checkOutput("clear_stall", 64'(stall_a), 64'd0);

        // Drain on the MAX_OUTSTANDING=4 instance with three reads in flight.
        up_b.mcmd_valid  = 1'b1;
        up_b.mcmd        = PZCOREBUS_READ;
        dn_b.scmd_accept = 1'b1;
        repeat (3) tick();
        up_b.mcmd_valid = 1'b0;
        checkOutput("drain_pre_count", 64'(count_b), 64'd3);
        checkOutput("drain_pre_limit", 64'(limit_b), 64'd0);
        drain = 1'b1;
        tick();
        up_b.mcmd_valid = 1'b1;
        #1;
        checkOutput("drain_block_read", 64'(up_b.scmd_accept), 64'd0);
        checkOutput("drain_block_read_valid", 64'(dn_b.mcmd_valid), 64'd0);
        up_b.mcmd = PZCOREBUS_WRITE;
        up_b.mdata_valid  = 1'b1;
        dn_b.sdata_accept = 1'b1;
        #1;
        checkOutput("drain_block_write", 64'(up_b.scmd_accept), 64'd0);
        checkOutput("drain_data_pass", 64'(up_b.sdata_accept), 64'd1);
        up_b.mdata_valid  = 1'b0;
        dn_b.sresp_valid  = 1'b1;
        dn_b.sresp_last   = 2'b01;
        up_b.mresp_accept = 1'b1;
        repeat (3) tick();
        dn_b.sresp_valid = 1'b0;
        checkOutput("drain_count_zero", 64'(count_b), 64'd0);
        checkOutput("drain_idle_not_yet", 64'(idle_b), 64'd0);
        tick();
        checkOutput("drain_idle", 64'(idle_b), 64'd1);
        checkOutput("idle_block_write", 64'(up_b.scmd_accept), 64'd0);
        drain = 1'b0;
        tick();
        checkOutput("undrain_idle", 64'(idle_b), 64'd0);
        checkOutput("undrain_accept", 64'(up_b.scmd_accept), 64'd1);
        tick();
        up_b.mcmd_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
